// File: rtl/map_table_pkg.sv
// Shared rename-map types and sizing for the R10K map table and its checkpoint slots.
// Also holds the identity map and the CDB ready-bit update applied to whole maps.
package map_table_pkg;

    localparam int LRF_NUM   = 32;
    localparam int PRF_NUM   = 64;
    localparam int BR_NUM    = 4;
    localparam int LRF_IDX_W = $clog2(LRF_NUM);
    localparam int PRF_IDX_W = $clog2(PRF_NUM);
    localparam int BR_IDX_W  = $clog2(BR_NUM);

    localparam logic [LRF_IDX_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [PRF_IDX_W-1:0] preg;
        logic                 rdy;
    } map_entry_t;

    typedef map_entry_t [LRF_NUM-1:0] map_t;

    // Architectural register i lives in physical register i after reset.
    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < LRF_NUM; i++) begin
            m[i].preg = PRF_IDX_W'(i);
            m[i].rdy  = 1'b1;
        end
        return m;
    endfunction

    function automatic map_t cdb_apply(input map_t m, input logic vld,
                                       input logic [PRF_IDX_W-1:0] tag);
        map_t r;
        r = m;
        for (int i = 0; i < LRF_NUM; i++) begin
            if (vld && (m[i].preg == tag)) begin
                r[i].rdy = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/map_table_ckpt.sv
// One branch checkpoint of the rename map. Keeps tracking CDB completions while
// it sits idle so a later restore does not bring back stale ready bits.
module map_table_ckpt
    import map_table_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  map_t                 wr_map,
    input  logic                 cdb_vld,
    input  logic [PRF_IDX_W-1:0] cdb_tag,
    output map_t                 rd_map
);

    map_t r_map;

    // wr_map is already the post-edge table, so it carries this cycle's CDB update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_map <= identity_map();
        end else if (wr_en) begin
            r_map <= wr_map;
        end else begin
            r_map <= cdb_apply(r_map, cdb_vld, cdb_tag);
        end
    end

    assign rd_map = r_map;

endmodule

// File: rtl/map_table.sv
// Rename-stage architectural-to-physical register map with per-entry ready bits,
// CDB wakeup, and BR_NUM branch checkpoints restored on mispredict.
module map_table
    import map_table_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dispatch_en_i,
    input  logic [LRF_IDX_W-1:0] dest_areg_i,
    input  logic [LRF_IDX_W-1:0] opa_areg_i,
    input  logic [LRF_IDX_W-1:0] opb_areg_i,
    input  logic [PRF_IDX_W-1:0] new_preg_i,
    input  logic                 cdb_vld_i,
    input  logic [PRF_IDX_W-1:0] cdb_tag_i,
    input  logic                 ckpt_en_i,
    input  logic [BR_IDX_W-1:0]  ckpt_idx_i,
    input  logic                 recover_en_i,
    input  logic [BR_IDX_W-1:0]  recover_idx_i,
    output logic [PRF_IDX_W-1:0] opa_preg_o,
    output logic                 opa_rdy_o,
    output logic [PRF_IDX_W-1:0] opb_preg_o,
    output logic                 opb_rdy_o,
    output logic [PRF_IDX_W-1:0] old_preg_o
);

    map_t              r_tbl;
    map_t              w_tbl_next;
    map_t              w_slot [BR_NUM];
    logic [BR_NUM-1:0] w_ckpt_wr;
    map_entry_t        w_opa_ent;
    map_entry_t        w_opb_ent;
    map_entry_t        w_dest_ent;

    // Recovery replaces the whole table; otherwise the rename overrides the CDB wakeup.
    always_comb begin
        w_tbl_next = cdb_apply(r_tbl, cdb_vld_i, cdb_tag_i);
        if (recover_en_i) begin
            w_tbl_next = cdb_apply(w_slot[recover_idx_i], cdb_vld_i, cdb_tag_i);
        end else if (dispatch_en_i) begin
            w_tbl_next[dest_areg_i].preg = new_preg_i;
            w_tbl_next[dest_areg_i].rdy  = 1'b0;
        end
    end

    always_comb begin
        w_ckpt_wr = '0;
        if (ckpt_en_i && !recover_en_i) begin
            w_ckpt_wr[ckpt_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tbl <= identity_map();
        end else begin
            r_tbl <= w_tbl_next;
        end
    end

    for (genvar k = 0; k < BR_NUM; k++) begin : g_ckpt
        map_table_ckpt u_ckpt (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (w_ckpt_wr[k]),
            .wr_map  (w_tbl_next),
            .cdb_vld (cdb_vld_i),
            .cdb_tag (cdb_tag_i),
            .rd_map  (w_slot[k])
        );
    end

    // Sources read the pre-rename table, with same-cycle CDB bypass on the ready bit.
    assign w_opa_ent  = r_tbl[opa_areg_i];
    assign w_opb_ent  = r_tbl[opb_areg_i];
    assign w_dest_ent = r_tbl[dest_areg_i];

    assign opa_preg_o = w_opa_ent.preg;
    assign opa_rdy_o  = w_opa_ent.rdy | (cdb_vld_i && (cdb_tag_i == w_opa_ent.preg));
    assign opb_preg_o = w_opb_ent.preg;
    assign opb_rdy_o  = w_opb_ent.rdy | (cdb_vld_i && (cdb_tag_i == w_opb_ent.preg));
    assign old_preg_o = w_dest_ent.preg;

endmodule

// File: doc/map_table.md
Name: map_table

Overview:
- Rename-stage register map for the R10K pipeline. Maps each architectural register to its current physical register (preg), with a per-entry ready bit.
- Consumes the free preg popped from the free list at dispatch. Supplies source tags/ready bits to the RS and the displaced (old) preg to the ROB; the ROB later retires that old preg back into the free list.
- Holds BR_NUM branch checkpoints, snapshotted at branch dispatch and restored on mispredict.

Parameters:
- LRF_NUM, 32, number of architectural registers
- LRF_IDX_W, 5, architectural register index width
- PRF_NUM, 64, number of physical registers
- PRF_IDX_W, 6, physical register index width
- BR_NUM, 4, number of checkpoint slots
- BR_IDX_W, 2, checkpoint slot index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dispatch_en_i  in  1  rename one instruction this cycle
- dest_areg_i  in  LRF_IDX_W  destination arch reg
- opa_areg_i  in  LRF_IDX_W  source A arch reg
- opb_areg_i  in  LRF_IDX_W  source B arch reg
- new_preg_i  in  PRF_IDX_W  free preg from the free list
- cdb_vld_i  in  1  CDB broadcast valid
- cdb_tag_i  in  PRF_IDX_W  preg completed on the CDB
- ckpt_en_i  in  1  take a checkpoint (branch dispatch)
- ckpt_idx_i  in  BR_IDX_W  slot to write
- recover_en_i  in  1  mispredict: restore a slot
- recover_idx_i  in  BR_IDX_W  slot to restore
- opa_preg_o  out  PRF_IDX_W  source A tag
- opa_rdy_o  out  1  source A value available
- opb_preg_o  out  PRF_IDX_W  source B tag
- opb_rdy_o  out  1  source B value available
- old_preg_o  out  PRF_IDX_W  previous mapping of dest_areg_i, to the ROB

Behaviour:
- Reset:
  - Entry i maps to preg i with rdy=1, for i = 0..LRF_NUM-1. This complements the free list's initial contents (pregs LRF_NUM..PRF_NUM-1).
  - All checkpoint slots are cleared to the same identity map.
- Outputs: combinational reads of the registered table, with zero-cycle latency. Outputs are valid every cycle regardless of dispatch_en_i; during the reset cycle they reflect the pre-reset register contents.
- Source reads:
  - Sources always see the mapping before this cycle's rename. If opa_areg_i == dest_areg_i, opa_preg_o is the old preg.
  - CDB bypass: if cdb_vld_i && cdb_tag_i == the looked-up preg, the corresponding rdy output is 1 in the same cycle.
- old_preg_o = table[dest_areg_i].preg, read before the update.
- Rename: if dispatch_en_i && !recover_en_i, then at the clock edge table[dest_areg_i] <= {new_preg_i, rdy=0}.
- Upstream never asserts dispatch_en_i with dest = ZERO_REG. That case is illegal stimulus and the bench flags it.
- CDB update: at the clock edge, every table entry whose preg == cdb_tag_i sets rdy=1. The same update applies to every checkpoint slot, so that restored snapshots are not stale.
- Same-cycle conflicts:
  - CDB and rename hit the same entry: the rename wins (rdy=0).
  - new_preg_i == cdb_tag_i is impossible (the preg is free) and is not checked.
- Checkpoint:
  - If ckpt_en_i, slot[ckpt_idx_i] <= the table state as it will be after this edge, i.e. including this cycle's rename and CDB updates.
  - Overwriting a live slot is permitted; the branch stack owns slot allocation.
- Recovery:
  - If recover_en_i, table <= slot[recover_idx_i] with this cycle's CDB update applied.
  - A same-cycle dispatch_en_i and ckpt_en_i are ignored; recovery has priority.
- Priority order: rst > recover_en_i > dispatch/ckpt > CDB-only.
- Widths: all tag comparisons are full PRF_IDX_W; no wrap arithmetic is involved.

Decomposition:
- Shared package (alongside the existing `BR_STATE_W / `ZERO_REG defines) holds:
  - LRF_NUM, PRF_NUM, LRF_IDX_W, PRF_IDX_W, BR_NUM, BR_IDX_W
  - typedef map_entry_t {preg[PRF_IDX_W], rdy}
  - typedef map_t = map_entry_t[LRF_NUM]
- One sub-module, map_table_ckpt: a single snapshot slot with inputs wr_en, wr_map, cdb_vld, cdb_tag and output rd_map. Instantiate it BR_NUM times.

Test Plan:
- Reset, then read opa=3, opb=7 -> preg 3/7, rdy=1/1; old_preg_o for dest 5 = 5.
- Dispatch dest=5, new=40; next cycle read opa=5 -> 40, rdy=0. Same-cycle read with opa=dest=5 -> 5, rdy=1; old_preg_o=5.
- Entry 5 holds preg 40, not ready:
  - cdb_vld with tag 40 and read opa=5 in the same cycle -> opa_rdy_o=1; the next cycle shows rdy=1 from the register.
  - Dispatch dest=5 new=41 with cdb tag 40 in the same cycle -> entry 5 = {41, 0}.
- Checkpoint slot 2 together with dispatch dest=9 new=50. Then dispatch dest=9 new=51, then broadcast tag 50. Recover slot 2 -> opa=9 reads preg 50, rdy=1.
- recover_en_i with dispatch_en_i (dest=4, new=60) in the same cycle -> dispatch is dropped; entry 4 equals the slot contents.
- Assert rst after several renames -> next cycle every entry i = {i, 1}, and all slots are the identity map.
